// File: rtl/decode_pkg.sv
// Shared decode definitions: one-hot instruction formats, execution unit IDs,
// primary opcodes and the primary-opcode -> format classifier.
package decode_pkg;

    localparam int FMT_W = 26;

    typedef logic [FMT_W-1:0] fmt_t;

    localparam fmt_t FMT_NONE = '0;
    localparam fmt_t FMT_I    = fmt_t'(1) << 0;
    localparam fmt_t FMT_B    = fmt_t'(1) << 1;
    localparam fmt_t FMT_SC   = fmt_t'(1) << 2;
    localparam fmt_t FMT_D    = fmt_t'(1) << 3;
    localparam fmt_t FMT_DS   = fmt_t'(1) << 4;
    localparam fmt_t FMT_DQ   = fmt_t'(1) << 5;
    localparam fmt_t FMT_DX   = fmt_t'(1) << 6;
    localparam fmt_t FMT_X    = fmt_t'(1) << 7;
    localparam fmt_t FMT_XL   = fmt_t'(1) << 8;
    localparam fmt_t FMT_XFX  = fmt_t'(1) << 9;
    localparam fmt_t FMT_XFL  = fmt_t'(1) << 10;
    localparam fmt_t FMT_XX1  = fmt_t'(1) << 11;
    localparam fmt_t FMT_XX2  = fmt_t'(1) << 12;
    localparam fmt_t FMT_XX3  = fmt_t'(1) << 13;
    localparam fmt_t FMT_XX4  = fmt_t'(1) << 14;
    localparam fmt_t FMT_XS   = fmt_t'(1) << 15;
    localparam fmt_t FMT_XO   = fmt_t'(1) << 16;
    localparam fmt_t FMT_A    = fmt_t'(1) << 17;
    localparam fmt_t FMT_M    = fmt_t'(1) << 18;
    localparam fmt_t FMT_MD   = fmt_t'(1) << 19;
    localparam fmt_t FMT_MDS  = fmt_t'(1) << 20;
    localparam fmt_t FMT_VA   = fmt_t'(1) << 21;
    localparam fmt_t FMT_VC   = fmt_t'(1) << 22;
    localparam fmt_t FMT_VX   = fmt_t'(1) << 23;
    localparam fmt_t FMT_EVX  = fmt_t'(1) << 24;
    localparam fmt_t FMT_Z23  = fmt_t'(1) << 25;

    typedef enum logic [2:0] {
        UNIT_FX     = 3'd0,
        UNIT_FP     = 3'd1,
        UNIT_VX     = 3'd2,
        UNIT_CR     = 3'd3,
        UNIT_LS     = 3'd4,
        UNIT_BRANCH = 3'd5
    } unit_e;

    localparam logic [5:0] OP_ILLEGAL = 6'd0;
    localparam logic [5:0] OP_VX      = 6'd4;
    localparam logic [5:0] OP_BC      = 6'd16;
    localparam logic [5:0] OP_SC      = 6'd17;
    localparam logic [5:0] OP_B       = 6'd18;
    localparam logic [5:0] OP_XL      = 6'd19;
    localparam logic [5:0] OP_RLWIMI  = 6'd20;
    localparam logic [5:0] OP_RLWINM  = 6'd21;
    localparam logic [5:0] OP_RLMI    = 6'd22;
    localparam logic [5:0] OP_RLWNM   = 6'd23;
    localparam logic [5:0] OP_MD      = 6'd30;
    localparam logic [5:0] OP_X31     = 6'd31;
    localparam logic [5:0] OP_DS58    = 6'd58;
    localparam logic [5:0] OP_FP59    = 6'd59;
    localparam logic [5:0] OP_DS62    = 6'd62;
    localparam logic [5:0] OP_FP63    = 6'd63;

    localparam logic [4:0] XO_ISEL  = 5'd15;
    localparam logic [4:0] XO_A_MIN = 5'd18;

    // Bit 0 of the POWER word is our bit 31, so instruction[0:5] is [31:26]
    // and instruction[26:30] is [5:1].
    function automatic fmt_t formatOf(input logic [31:0] instruction);
        logic [5:0] op;
        logic [4:0] xo;
        op = instruction[31:26];
        xo = instruction[5:1];
        case (op)
            OP_ILLEGAL:                               formatOf = FMT_NONE;
            OP_VX:                                    formatOf = FMT_VX;
            OP_BC:                                    formatOf = FMT_B;
            OP_SC:                                    formatOf = FMT_SC;
            OP_B:                                     formatOf = FMT_I;
            OP_XL:                                    formatOf = FMT_XL;
            OP_RLWIMI, OP_RLWINM, OP_RLMI, OP_RLWNM:  formatOf = FMT_M;
            OP_MD:                                    formatOf = FMT_MD;
            OP_DS58, OP_DS62:                         formatOf = FMT_DS;
            OP_X31:            formatOf = (xo == XO_ISEL)  ? FMT_A : FMT_X;
            OP_FP59, OP_FP63:  formatOf = (xo >= XO_A_MIN) ? FMT_A : FMT_X;
            default:                                  formatOf = FMT_D;
        endcase
    endfunction

endpackage

// File: rtl/issue_fifo.sv
// Generic synchronous FIFO with show-ahead head output; full is registered
// from the next-state occupancy so it can drive an upstream stall directly.
module issue_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             clear_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [PW:0]      count_q;
    logic [PW:0]      count_d;
    logic             full_q;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop_i && (count_q != '0);
    assign do_push = push_i && ((count_q != DEPTH_C) || do_pop);

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else begin
            count_d = count_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
        end
    end

    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            full_q  <= (count_d == DEPTH_C);
            if (clear_i) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
                if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    // Storage carries no reset so it can map onto distributed RAM.
    always_ff @(posedge clock_i) begin
        if (do_push && !clear_i) mem_q[wr_ptr_q] <= data_i;
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign full_o  = full_q;
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/inst_format_issuer.sv
// Issue stage: classifies fetched words, tags them with a major ID, buffers
// them and drives the decoder bundle. INST_FORMAT_ISSUER_ILLEGAL_EN adds illegalOpcode_o.
module inst_format_issuer
    import decode_pkg::*;
#(
    parameter int addressWidth            = 64,
    parameter int instructionWidth        = 32,
    parameter int PidSize                 = 20,
    parameter int TidSize                 = 16,
    parameter int instructionCounterWidth = 64,
    parameter int PrimOpcodeSize          = 6,
    parameter int fifoDepth               = 4
) (
    input  logic                               clock_i,
    input  logic                               reset_i,
    input  logic                               enable_i,
    input  logic [instructionWidth-1:0]        instruction_i,
    input  logic [addressWidth-1:0]            instructionAddress_i,
    input  logic                               is64Bit_i,
    input  logic [PidSize-1:0]                 instructionPid_i,
    input  logic [TidSize-1:0]                 instructionTid_i,
    input  logic                               flush_i,
    input  logic                               stall_i,
    output logic                               stall_o,
    output logic                               enable_o,
    output logic [FMT_W-1:0]                   instFormat_o,
    output logic [PrimOpcodeSize-1:0]          instructionOpcode_o,
    output logic [instructionWidth-1:0]        instruction_o,
    output logic [addressWidth-1:0]            instructionAddress_o,
    output logic                               is64Bit_o,
    output logic [PidSize-1:0]                 instructionPid_o,
    output logic [TidSize-1:0]                 instructionTid_o,
    output logic [instructionCounterWidth-1:0] instructionMajId_o
`ifdef INST_FORMAT_ISSUER_ILLEGAL_EN
    ,
    output logic                               illegalOpcode_o
`endif
);
    typedef struct packed {
        logic [FMT_W-1:0]                   fmt;
        logic [instructionWidth-1:0]        instr;
        logic [addressWidth-1:0]            addr;
        logic                               is64;
        logic [PidSize-1:0]                 pid;
        logic [TidSize-1:0]                 tid;
        logic [instructionCounterWidth-1:0] maj_id;
    } entry_t;

    logic [instructionCounterWidth-1:0] maj_id_q;
    entry_t     out_q;
    logic       out_valid_q;
    entry_t     entry_in;
    entry_t     fifo_head;
    fmt_t       fmt_in;
    logic       accept;
    logic       load_ok;
    logic       bypass;
    logic       fifo_push;
    logic       fifo_pop;
    logic       fifo_full;
    logic       fifo_empty;

    assign fmt_in = formatOf(instruction_i);

`ifdef INST_FORMAT_ISSUER_ILLEGAL_EN
    assign accept = enable_i && !fifo_full && !flush_i;
`else
    // Illegal words are dropped here, before they can consume a major ID.
    assign accept = enable_i && !fifo_full && !flush_i && (fmt_in != FMT_NONE);
`endif

    assign entry_in = '{
        fmt:    fmt_in,
        instr:  instruction_i,
        addr:   instructionAddress_i,
        is64:   is64Bit_i,
        pid:    instructionPid_i,
        tid:    instructionTid_i,
        maj_id: maj_id_q
    };

    assign load_ok   = !out_valid_q || !stall_i;
    assign bypass    = accept && fifo_empty && load_ok;
    assign fifo_push = accept && !bypass;
    assign fifo_pop  = load_ok && !fifo_empty && !flush_i;

    issue_fifo #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (fifoDepth)
    ) u_fifo (
        .clock_i (clock_i),
        .reset_i (reset_i),
        .clear_i (flush_i),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .data_i  (entry_in),
        .data_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            maj_id_q <= '0;
        end else if (accept) begin
            maj_id_q <= maj_id_q + 1'b1;
        end
    end

    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else if (flush_i) begin
            out_valid_q <= 1'b0;
        end else if (load_ok) begin
            if (!fifo_empty) begin
                out_q       <= fifo_head;
                out_valid_q <= 1'b1;
            end else if (accept) begin
                out_q       <= entry_in;
                out_valid_q <= 1'b1;
            end else begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign stall_o              = fifo_full;
    assign enable_o             = out_valid_q;
    assign instFormat_o         = out_q.fmt;
    assign instructionOpcode_o  = out_q.instr[instructionWidth-1 -: PrimOpcodeSize];
    assign instruction_o        = out_q.instr;
    assign instructionAddress_o = out_q.addr;
    assign is64Bit_o            = out_q.is64;
    assign instructionPid_o     = out_q.pid;
    assign instructionTid_o     = out_q.tid;
    assign instructionMajId_o   = out_q.maj_id;

`ifdef INST_FORMAT_ISSUER_ILLEGAL_EN
    assign illegalOpcode_o = out_valid_q && (out_q.fmt == FMT_NONE);
`endif

endmodule

// File: tb/tb_inst_format_issuer.sv
// Directed bench for inst_format_issuer: format table vectors plus hand-built
// sequences for back-pressure, flush, ID wrap and illegal opcodes.
module tb_inst_format_issuer;
    import decode_pkg::*;

    logic        clock_i = 1'b0;
    logic        reset_i;
    logic        enable_i;
    logic [31:0] instruction_i;
    logic [63:0] instructionAddress_i;
    logic        is64Bit_i;
    logic [19:0] instructionPid_i;
    logic [15:0] instructionTid_i;
    logic        flush_i;
    logic        stall_i;
    logic        stall_o;
    logic        enable_o;
    logic [25:0] instFormat_o;
    logic [5:0]  instructionOpcode_o;
    logic [31:0] instruction_o;
    logic [63:0] instructionAddress_o;
    logic        is64Bit_o;
    logic [19:0] instructionPid_o;
    logic [15:0] instructionTid_o;
    logic [63:0] instructionMajId_o;
`ifdef INST_FORMAT_ISSUER_ILLEGAL_EN
    logic        illegalOpcode_o;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clock_i = ~clock_i;

    inst_format_issuer dut (
        .clock_i              (clock_i),
        .reset_i              (reset_i),
        .enable_i             (enable_i),
        .instruction_i        (instruction_i),
        .instructionAddress_i (instructionAddress_i),
        .is64Bit_i            (is64Bit_i),
        .instructionPid_i     (instructionPid_i),
        .instructionTid_i     (instructionTid_i),
        .flush_i              (flush_i),
        .stall_i              (stall_i),
        .stall_o              (stall_o),
        .enable_o             (enable_o),
        .instFormat_o         (instFormat_o),
        .instructionOpcode_o  (instructionOpcode_o),
        .instruction_o        (instruction_o),
        .instructionAddress_o (instructionAddress_o),
        .is64Bit_o            (is64Bit_o),
        .instructionPid_o     (instructionPid_o),
        .instructionTid_o     (instructionTid_o),
        .instructionMajId_o   (instructionMajId_o)
`ifdef INST_FORMAT_ISSUER_ILLEGAL_EN
        ,
        .illegalOpcode_o      (illegalOpcode_o)
`endif
    );

    typedef struct {
        logic [5:0]  op;
        logic [4:0]  xo;
        logic [25:0] fmt;
    } vec_t;

    vec_t vecs[18];

    task automatic tick();
        @(posedge clock_i);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic en, input logic [5:0] op, input logic [4:0] xo,
                         input logic [63:0] addr);
        enable_i             = en;
        instruction_i        = {op, 20'h0, xo, 1'b0};
        instructionAddress_i = addr;
        is64Bit_i            = addr[2];
        instructionPid_i     = 20'h12345 ^ addr[19:0];
        instructionTid_i     = addr[15:0];
    endtask

    task automatic do_reset();
        reset_i  = 1'b0;
        enable_i = 1'b0;
        flush_i  = 1'b0;
        stall_i  = 1'b0;
        drive(1'b0, 6'd0, 5'd0, 64'h0);
        tick();
        tick();
        reset_i = 1'b1;
    endtask

    initial begin
        logic [63:0] exp_id;
        vecs[0]  = '{6'd18, 5'd0,  FMT_I};
        vecs[1]  = '{6'd16, 5'd0,  FMT_B};
        vecs[2]  = '{6'd17, 5'd0,  FMT_SC};
        vecs[3]  = '{6'd19, 5'd0,  FMT_XL};
        vecs[4]  = '{6'd4,  5'd0,  FMT_VX};
        vecs[5]  = '{6'd20, 5'd0,  FMT_M};
        vecs[6]  = '{6'd23, 5'd0,  FMT_M};
        vecs[7]  = '{6'd30, 5'd0,  FMT_MD};
        vecs[8]  = '{6'd58, 5'd0,  FMT_DS};
        vecs[9]  = '{6'd62, 5'd0,  FMT_DS};
        vecs[10] = '{6'd31, 5'd15, FMT_A};
        vecs[11] = '{6'd31, 5'd10, FMT_X};
        vecs[12] = '{6'd59, 5'd17, FMT_X};
        vecs[13] = '{6'd59, 5'd18, FMT_A};
        vecs[14] = '{6'd63, 5'd31, FMT_A};
        vecs[15] = '{6'd63, 5'd0,  FMT_X};
        vecs[16] = '{6'd14, 5'd0,  FMT_D};
        vecs[17] = '{6'd32, 5'd0,  FMT_D};

        // Reset state
        do_reset();
        tick();
        check("reset_enable", 64'(enable_o), 64'd0);
        check("reset_stall", 64'(stall_o), 64'd0);
        check("reset_majid", instructionMajId_o, 64'd0);
        check("reset_fmt", 64'(instFormat_o), 64'd0);

        // Single word, latency 1
        enable_i             = 1'b1;
        instruction_i        = 32'hEC00_002A;
        instructionAddress_i = 64'h100;
        tick();
        enable_i = 1'b0;
        check("t1_enable", 64'(enable_o), 64'd1);
        check("t1_fmt", 64'(instFormat_o), 64'(FMT_A));
        check("t1_opcode", 64'(instructionOpcode_o), 64'd59);
        check("t1_majid", instructionMajId_o, 64'd0);
        check("t1_addr", instructionAddress_o, 64'h100);

        // Format table, back-to-back
        exp_id = 64'd1;
        for (int i = 0; i < 18; i++) begin
            drive(1'b1, vecs[i].op, vecs[i].xo, 64'h1000 + 64'(i * 4));
            tick();
            check($sformatf("vec%0d_enable", i), 64'(enable_o), 64'd1);
            check($sformatf("vec%0d_fmt", i), 64'(instFormat_o), 64'(vecs[i].fmt));
            check($sformatf("vec%0d_opcode", i), 64'(instructionOpcode_o), 64'(vecs[i].op));
            check($sformatf("vec%0d_majid", i), instructionMajId_o, exp_id);
            check($sformatf("vec%0d_pid", i), 64'(instructionPid_o),
                  64'(20'h12345 ^ (20'h01000 + 20'(i * 4))));
            exp_id++;
        end
        enable_i = 1'b0;
        tick();
        check("vec_drain_enable", 64'(enable_o), 64'd0);

        // Fill under stall: stall_o after 5th accept, 6th dropped
        do_reset();
        stall_i = 1'b1;
        for (int k = 0; k < 6; k++) begin
            drive(1'b1, 6'd14, 5'd0, 64'h2000 + 64'(k * 4));
            tick();
            check($sformatf("t2_stall_k%0d", k), 64'(stall_o), (k >= 4) ? 64'd1 : 64'd0);
        end
        enable_i = 1'b0;
        check("t2_hold_majid", instructionMajId_o, 64'd0);
        stall_i = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            tick();
            check($sformatf("t2_majid_%0d", k), instructionMajId_o, 64'(k));
            check($sformatf("t2_addr_%0d", k), instructionAddress_o, 64'h2000 + 64'(k * 4));
            if (k == 1) check("t2_stall_release", 64'(stall_o), 64'd0);
        end
        tick();
        check("t2_empty_enable", 64'(enable_o), 64'd0);

        // Outputs bit-stable while stalled
        do_reset();
        stall_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 6'd18, 5'd0, 64'h3000 + 64'(k * 4));
            tick();
        end
        enable_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("t3_hold_en_%0d", k), 64'(enable_o), 64'd1);
            check($sformatf("t3_hold_id_%0d", k), instructionMajId_o, 64'd0);
            check($sformatf("t3_hold_addr_%0d", k), instructionAddress_o, 64'h3000);
            check($sformatf("t3_hold_instr_%0d", k), 64'(instruction_o), 64'h4800_0000);
        end
        stall_i = 1'b0;
        tick();
        check("t3_release_id", instructionMajId_o, 64'd1);
        check("t3_release_addr", instructionAddress_o, 64'h3004);

        // Flush with concurrent enable, stall still high
        do_reset();
        stall_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 6'd14, 5'd0, 64'h4000 + 64'(k * 4));
            tick();
        end
        check("t4_prefl_stall", 64'(stall_o), 64'd0);
        flush_i = 1'b1;
        drive(1'b1, 6'd14, 5'd0, 64'h4100);
        tick();
        flush_i  = 1'b0;
        enable_i = 1'b0;
        check("t4_flush_enable", 64'(enable_o), 64'd0);
        check("t4_flush_stall", 64'(stall_o), 64'd0);
        stall_i = 1'b0;
        tick();
        check("t4_fifo_empty", 64'(enable_o), 64'd0);
        drive(1'b1, 6'd14, 5'd0, 64'h4200);
        tick();
        enable_i = 1'b0;
        check("t4_next_enable", 64'(enable_o), 64'd1);
        check("t4_next_majid", instructionMajId_o, 64'd4);

        // Major ID wrap
        do_reset();
        dut.maj_id_q = 64'hFFFF_FFFF_FFFF_FFFF;
        drive(1'b1, 6'd14, 5'd0, 64'h5000);
        tick();
        check("t5_max_id", instructionMajId_o, 64'hFFFF_FFFF_FFFF_FFFF);
        drive(1'b1, 6'd14, 5'd0, 64'h5004);
        tick();
        enable_i = 1'b0;
        check("t5_wrap_id", instructionMajId_o, 64'd0);

        // Primary opcode 0
        do_reset();
        drive(1'b1, 6'd0, 5'd0, 64'h6000);
        tick();
`ifdef INST_FORMAT_ISSUER_ILLEGAL_EN
        check("t6_ill_enable", 64'(enable_o), 64'd1);
        check("t6_ill_fmt", 64'(instFormat_o), 64'd0);
        check("t6_ill_flag", 64'(illegalOpcode_o), 64'd1);
        drive(1'b1, 6'd14, 5'd0, 64'h6004);
        tick();
        enable_i = 1'b0;
        check("t6_next_majid", instructionMajId_o, 64'd1);
        check("t6_next_flag", 64'(illegalOpcode_o), 64'd0);
`else
        check("t6_drop_enable", 64'(enable_o), 64'd0);
        drive(1'b1, 6'd14, 5'd0, 64'h6004);
        tick();
        enable_i = 1'b0;
        check("t6_next_enable", 64'(enable_o), 64'd1);
        check("t6_next_majid", instructionMajId_o, 64'd0);
        check("t6_next_addr", instructionAddress_o, 64'h6004);
`endif

        // Reset mid-traffic clears everything
        stall_i = 1'b1;
        drive(1'b1, 6'd14, 5'd0, 64'h7000);
        tick();
        reset_i = 1'b0;
        tick();
        reset_i  = 1'b1;
        enable_i = 1'b0;
        stall_i  = 1'b0;
        check("t7_reset_enable", 64'(enable_o), 64'd0);
        check("t7_reset_addr", instructionAddress_o, 64'd0);
        tick();
        check("t7_after_enable", 64'(enable_o), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
